seven_segment_scan_ctrl: RTL and testbench

Time-multiplexing controller that shares one active-low seven-segment bus (led_out) between NUM_DIGITS digit drivers. It scans the digits round-robin, one at a time. A blanking gap separates each digit to avoid ghosting. It accepts new BCD display values through a valid/ready handshake, and commits them only at frame boundaries so a frame never tears. It sits between the seconds counters and the board's segment and digit-enable pins.

---
 rtl/seven_segment_scan_ctrl.sv | 164 ++++++++++++++++
 tb/tb_seven_segment_scan_ctrl.sv | 205 ++++++++++++++++++++
 2 files changed

// File: rtl/seven_segment_scan_ctrl.sv
// Round-robin seven-segment scanner with blanking gaps and frame-synchronous value commit.
// Optional build macro LEADING_ZERO_BLANK_EN suppresses leading zero digits (digit 0 always shown).
module seven_segment_scan_ctrl #(
    parameter int NUM_DIGITS  = 4,
    parameter int SCAN_COUNT  = 1000,
    parameter int BLANK_COUNT = 16
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [4*NUM_DIGITS-1:0] bcd_in,
    input  logic                    load_valid,
    output logic                    load_ready,
    output logic [6:0]              led_out,
    output logic [NUM_DIGITS-1:0]   digit_en,
    output logic                    frame_done
);

    localparam int MAX_COUNT = (SCAN_COUNT > BLANK_COUNT) ? SCAN_COUNT : BLANK_COUNT;
    localparam int TIMER_W   = (MAX_COUNT > 1) ? $clog2(MAX_COUNT) : 1;
    localparam int IDX_W     = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;

    localparam logic [TIMER_W-1:0] SCAN_LAST  = TIMER_W'(SCAN_COUNT - 1);
    localparam logic [TIMER_W-1:0] BLANK_LAST = TIMER_W'(BLANK_COUNT - 1);
    localparam logic [IDX_W-1:0]   IDX_LAST   = IDX_W'(NUM_DIGITS - 1);
    localparam logic [6:0]         SEG_OFF    = 7'h7F;

    typedef enum logic {
        ST_BLANK = 1'b0,
        ST_DRIVE = 1'b1
    } state_t;

    state_t                  state_q, state_d;
    logic [IDX_W-1:0]        idx_q, idx_d;
    logic [TIMER_W-1:0]      timer_q, timer_d;
    logic [4*NUM_DIGITS-1:0] pending_q, pending_d;
    logic                    pending_valid_q, pending_valid_d;
    logic [4*NUM_DIGITS-1:0] active_q, active_d;
    logic                    load_ready_q, load_ready_d;
    logic [6:0]              led_out_q, led_out_d;
    logic [NUM_DIGITS-1:0]   digit_en_q, digit_en_d;
    logic                    frame_done_q, frame_done_d;

    logic                    boundary;
    logic                    transfer;
    logic [6:0]              digit_seg [NUM_DIGITS];

    function automatic logic [6:0] seg_decode(input logic [3:0] value);
        logic [6:0] seg;
        case (value)
            4'd0:    seg = 7'h40;
            4'd1:    seg = 7'h79;
            4'd2:    seg = 7'h24;
            4'd3:    seg = 7'h30;
            4'd4:    seg = 7'h19;
            4'd5:    seg = 7'h12;
            4'd6:    seg = 7'h02;
            4'd7:    seg = 7'h78;
            4'd8:    seg = 7'h00;
            4'd9:    seg = 7'h10;
            default: seg = SEG_OFF;
        endcase
        return seg;
    endfunction

    // Segment pattern each digit would show if it were driven now.
    for (genvar gi = 0; gi < NUM_DIGITS; gi++) begin : g_digit_seg
`ifdef LEADING_ZERO_BLANK_EN
        if (gi == 0) begin : g_lsd
            assign digit_seg[gi] = seg_decode(active_q[4*gi +: 4]);
        end else begin : g_upper
            assign digit_seg[gi] = (active_q[4*NUM_DIGITS-1:4*gi] == '0)
                                 ? SEG_OFF : seg_decode(active_q[4*gi +: 4]);
        end
`else
        assign digit_seg[gi] = seg_decode(active_q[4*gi +: 4]);
`endif
    end

    assign boundary = (state_q == ST_DRIVE) && (timer_q == SCAN_LAST) && (idx_q == IDX_LAST);
    assign transfer = load_valid && load_ready_q;

    always_comb begin
        state_d         = state_q;
        idx_d           = idx_q;
        timer_d         = timer_q + 1'b1;
        pending_d       = pending_q;
        pending_valid_d = pending_valid_q;
        active_d        = active_q;
        led_out_d       = SEG_OFF;
        digit_en_d      = '0;

        case (state_q)
            ST_BLANK: begin
                if (timer_q == BLANK_LAST) begin
                    state_d = ST_DRIVE;
                    timer_d = '0;
                end
            end
            ST_DRIVE: begin
                if (timer_q == SCAN_LAST) begin
                    state_d = ST_BLANK;
                    timer_d = '0;
                    idx_d   = (idx_q == IDX_LAST) ? '0 : idx_q + 1'b1;
                end
            end
            default: begin
                state_d = ST_BLANK;
                timer_d = '0;
            end
        endcase

        // Only a value already pending before the boundary cycle is committed;
        // one accepted during the boundary cycle waits for the next frame.
        if (boundary && pending_valid_q) begin
            active_d        = pending_q;
            pending_valid_d = 1'b0;
        end
        if (transfer) begin
            pending_d       = bcd_in;
            pending_valid_d = 1'b1;
        end

        load_ready_d = !pending_valid_d;
        frame_done_d = boundary;

        // Outputs are loaded with the values of the state being entered.
        if (state_d == ST_DRIVE) begin
            digit_en_d = NUM_DIGITS'(1) << idx_d;
            led_out_d  = digit_seg[idx_d];
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q         <= ST_BLANK;
            idx_q           <= '0;
            timer_q         <= '0;
            pending_q       <= '0;
            pending_valid_q <= 1'b0;
            active_q        <= '0;
            load_ready_q    <= 1'b1;
            led_out_q       <= SEG_OFF;
            digit_en_q      <= '0;
            frame_done_q    <= 1'b0;
        end else begin
            state_q         <= state_d;
            idx_q           <= idx_d;
            timer_q         <= timer_d;
            pending_q       <= pending_d;
            pending_valid_q <= pending_valid_d;
            active_q        <= active_d;
            load_ready_q    <= load_ready_d;
            led_out_q       <= led_out_d;
            digit_en_q      <= digit_en_d;
            frame_done_q    <= frame_done_d;
        end
    end

    assign load_ready = load_ready_q;
    assign led_out    = led_out_q;
    assign digit_en   = digit_en_q;
    assign frame_done = frame_done_q;

endmodule

// File: tb/tb_seven_segment_scan_ctrl.sv
// Self-checking bench for seven_segment_scan_ctrl: directed scenarios plus random loads,
// compared every cycle against a frame-position reference model.
module tb_seven_segment_scan_ctrl;

    localparam int N     = 4;
    localparam int SCAN  = 8;
    localparam int BLANK = 2;
    localparam int SLOT  = SCAN + BLANK;
    localparam int FRAME = N * SLOT;

    logic           clk;
    logic           reset;
    logic [4*N-1:0] bcd_in;
    logic           load_valid;
    logic           load_ready;
    logic [6:0]     led_out;
    logic [N-1:0]   digit_en;
    logic           frame_done;

    int          tests;
    int          fails;
    int          k;
    logic [15:0] m_active;
    logic [15:0] m_pending;
    bit          m_pvalid;
    bit          last_xfer;
    logic [6:0]  dec_tab [16];

    seven_segment_scan_ctrl #(
        .NUM_DIGITS (N),
        .SCAN_COUNT (SCAN),
        .BLANK_COUNT(BLANK)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .bcd_in    (bcd_in),
        .load_valid(load_valid),
        .load_ready(load_ready),
        .led_out   (led_out),
        .digit_en  (digit_en),
        .frame_done(frame_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, k);
        end
    endtask

    // Expected segment pattern for digit d from the committed display value.
    function automatic logic [6:0] exp_seg(input int d);
        logic [15:0] upper;
        upper = m_active >> (4 * d);
`ifdef LEADING_ZERO_BLANK_EN
        if (d > 0 && upper == 16'h0) return 7'h7F;
`endif
        return dec_tab[upper[3:0]];
    endfunction

    // Outputs depend only on the position within the 40-cycle frame.
    task automatic check_outputs();
        int p;
        int off;
        int d;
        logic [N-1:0] en_exp;
        logic [6:0]   seg_exp;
        p   = k % FRAME;
        off = p % SLOT;
        d   = p / SLOT;
        if (off < BLANK) begin
            en_exp  = '0;
            seg_exp = 7'h7F;
        end else begin
            en_exp  = N'(1) << d;
            seg_exp = exp_seg(d);
        end
        check_eq("digit_en", 32'(digit_en), 32'(en_exp));
        check_eq("led_out", 32'(led_out), 32'(seg_exp));
        check_eq("frame_done", 32'(frame_done), 32'(k > 0 && p == 0));
        check_eq("load_ready", 32'(load_ready), 32'(!m_pvalid));
    endtask

    task automatic tick();
        bit xfer;
        bit commit;
        @(posedge clk);
        xfer   = load_valid && !m_pvalid;
        k++;
        commit = (k % FRAME == 0) && m_pvalid;
        if (commit) begin
            m_active = m_pending;
            m_pvalid = 1'b0;
        end
        if (xfer) begin
            m_pending = bcd_in;
            m_pvalid  = 1'b1;
            $display("[TB] load %h accepted at cycle %0d (frame pos %0d)", bcd_in, k, k % FRAME);
        end
        last_xfer = xfer;
        #1;
        check_outputs();
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic run_until_phase(input int ph);
        for (int i = 0; i < FRAME && (k % FRAME) != ph; i++) tick();
    endtask

    task automatic load_value(input logic [15:0] v);
        int waited;
        bcd_in     = v;
        load_valid = 1'b1;
        waited     = 0;
        do begin
            tick();
            waited++;
        end while (!last_xfer && waited < 3 * FRAME);
        if (!last_xfer) check_eq("load_timeout", 32'(last_xfer), 32'd1);
        load_valid = 1'b0;
    endtask

    task automatic random_phase(input int n);
        for (int i = 0; i < n; i++) begin
            if (!load_valid && $urandom_range(0, 11) == 0) begin
                bcd_in = 16'($urandom);
                if ($urandom_range(0, 1) == 1) bcd_in[15:4] = 12'h0;
                else if ($urandom_range(0, 2) == 0) bcd_in[15:8] = 8'h0;
                load_valid = 1'b1;
            end
            tick();
            if (last_xfer) load_valid = 1'b0;
        end
    endtask

    initial begin
        dec_tab = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                    7'h00, 7'h10, 7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h7F};
        tests      = 0;
        fails      = 0;
        k          = 0;
        m_active   = '0;
        m_pending  = '0;
        m_pvalid   = 1'b0;
        last_xfer  = 1'b0;
        reset      = 1'b0;
        load_valid = 1'b0;
        bcd_in     = '0;

        // Power-on reset, checked before the first clock edge.
        #2 reset = 1'b1;
        #1;
        check_outputs();
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;

        run(2 * FRAME + 5);

        // Pending load must be discarded by an asynchronous reset mid-DRIVE.
        run_until_phase(3);
        load_value(16'h9999);
        run_until_phase(15);
        #3 reset = 1'b1;
        #1;
        check_eq("async_rst_led", 32'(led_out), 32'h7F);
        check_eq("async_rst_en", 32'(digit_en), 32'h0);
        check_eq("async_rst_ready", 32'(load_ready), 32'h1);
        @(posedge clk);
        #1 reset  = 1'b0;
        k         = 0;
        m_active  = '0;
        m_pvalid  = 1'b0;
        run(2 * FRAME);

        // Mid-frame load, committed at the following boundary.
        run_until_phase(15);
        load_value(16'h1234);
        run(2 * FRAME + 10);

        // Load accepted in the boundary cycle commits one frame later.
        run_until_phase(FRAME - 1);
        load_value(16'h5678);
        run(2 * FRAME + 10);

        load_value(16'hF005);
        run(2 * FRAME + 10);
        load_value(16'h0005);
        run(2 * FRAME + 10);
        load_value(16'h0000);
        run(2 * FRAME + 10);

        random_phase(1500);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
